// File: rtl/parser_pkg.sv
// parser_pkg: frame constants, FSM state type and type-byte helper shared by
// the msg_parser block and its sub-module.
package parser_pkg;

    localparam logic [7:0] MSG_TRADE = 8'h54;
    localparam logic [7:0] MSG_ADD   = 8'h41;

    // Bytes per frame excluding the optional trailing checksum byte.
    localparam int MSG_LEN = 17;

    localparam int IDX_W = 5;
    // Byte index of the last byte of each field inside a frame.
    localparam logic [IDX_W-1:0] IDX_OID_LAST   = 5'd8;
    localparam logic [IDX_W-1:0] IDX_PRICE_LAST = 5'd12;
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        CHK  = 2'd2
    } state_t;

    // True for type bytes that start a frame we know how to parse.
    function automatic logic is_known_type(input logic [7:0] b);
        return (b == MSG_TRADE) || (b == MSG_ADD);
    endfunction

endpackage

// File: rtl/msg_timeout_counter.sv
// msg_timeout_counter: counts idle cycles inside a message and flags expiry.
// The count clears on every accepted byte (i_clear) and whenever counting is
// not enabled. o_expired marks the edge at which the count would reach
// TIMEOUT_CYCLES-1; a byte accepted in that same cycle wins. TIMEOUT_CYCLES=0
// disables the timeout entirely.
module msg_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign o_expired = 1'b0;
        end else if (TIMEOUT_CYCLES == 1) begin : g_one
            // Any idle cycle at all is already too long.
            assign o_expired = i_enable && !i_clear;
        end else begin : g_cnt
            localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

            logic [CW-1:0] r_count;

            assign o_expired = i_enable && !i_clear && (r_count == LAST);

            // Idle-cycle counter: restarts on a byte, on leave of the message, or on expiry.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (i_clear || !i_enable || o_expired) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/msg_parser.sv
// msg_parser: frames 17-byte big-endian market messages (type, order_id,
// price, volume) from a valid/ready byte stream and presents one registered
// record per message. Unknown type bytes, stalled messages and (optionally)
// bad checksums are dropped and counted in a saturating error counter.
// Optional feature: define MSG_PARSER_CHECKSUM_EN to expect an 18th byte equal
// to the XOR of the 17 preceding bytes.
module msg_parser
    import parser_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERR_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             field_valid,
    input  logic             out_ready,
    output logic [7:0]       msg_type,
    output logic [63:0]      order_id,
    output logic [31:0]      price,
    output logic [31:0]      volume,
    output logic [ERR_W-1:0] err_count
);

    state_t            r_state;
    state_t            w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_type_sh;
    logic [63:0]       r_oid_sh;
    logic [31:0]       r_price_sh;
    logic [31:0]       r_vol_sh;
    logic [31:0]       w_vol_final;

    logic              r_field_valid;
    logic [7:0]        r_msg_type;
    logic [63:0]       r_order_id;
    logic [31:0]       r_price;
    logic [31:0]       r_volume;
    logic [ERR_W-1:0]  r_err_count;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_expired;
    logic              w_complete;
    logic              w_err_inc;

    // A pending record that nobody has taken blocks all input.
    assign w_in_ready = !r_field_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;

    msg_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_accept),
        .i_enable ((r_state != IDLE) && w_in_ready),
        .o_expired(w_expired)
    );

`ifdef MSG_PARSER_CHECKSUM_EN
    logic [7:0] r_xor;

    // Running XOR of every byte of the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xor <= '0;
        end else if (w_accept && (r_state == IDLE)) begin
            r_xor <= in_data;
        end else if (w_accept && (r_state == BODY)) begin
            r_xor <= r_xor ^ in_data;
        end
    end

    // The volume register is already complete when the checksum byte arrives.
    assign w_vol_final = r_vol_sh;
`else
    // Without a checksum the record completes on the last volume byte itself.
    assign w_vol_final = {r_vol_sh[23:0], in_data};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, frame-complete and error-event decode.
    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        w_err_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (is_known_type(in_data)) begin
                        w_state_next = BODY;
                    end else begin
                        w_err_inc = 1'b1;
                    end
                end
            end
            BODY: begin
                if (w_accept) begin
                    if (r_idx == IDX_LAST) begin
`ifdef MSG_PARSER_CHECKSUM_EN
                        w_state_next = CHK;
`else
                        w_state_next = IDLE;
                        w_complete   = 1'b1;
`endif
                    end
                end else if (w_expired) begin
                    w_state_next = IDLE;
                    w_err_inc    = 1'b1;
                end
            end
`ifdef MSG_PARSER_CHECKSUM_EN
            CHK: begin
                if (w_accept) begin
                    w_state_next = IDLE;
                    if (in_data == r_xor) begin
                        w_complete = 1'b1;
                    end else begin
                        w_err_inc = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_next = IDLE;
                    w_err_inc    = 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Byte index and big-endian field assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_type_sh  <= '0;
            r_oid_sh   <= '0;
            r_price_sh <= '0;
            r_vol_sh   <= '0;
        end else begin
            if (w_state_next == IDLE) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_accept && (r_state == IDLE) && is_known_type(in_data)) begin
                r_type_sh <= in_data;
            end else if (w_accept && (r_state == BODY)) begin
                if (r_idx <= IDX_OID_LAST) begin
                    r_oid_sh <= {r_oid_sh[55:0], in_data};
                end else if (r_idx <= IDX_PRICE_LAST) begin
                    r_price_sh <= {r_price_sh[23:0], in_data};
                end else begin
                    r_vol_sh <= {r_vol_sh[23:0], in_data};
                end
            end
        end
    end

    // Output record register with valid/ready hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_field_valid <= 1'b0;
            r_msg_type    <= '0;
            r_order_id    <= '0;
            r_price       <= '0;
            r_volume      <= '0;
        end else if (w_complete) begin
            r_field_valid <= 1'b1;
            r_msg_type    <= r_type_sh;
            r_order_id    <= r_oid_sh;
            r_price       <= r_price_sh;
            r_volume      <= w_vol_final;
        end else if (out_ready) begin
            r_field_valid <= 1'b0;
        end
    end

    // Saturating count of discarded bytes and messages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_err_inc && (r_err_count != {ERR_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign in_ready    = w_in_ready;
    assign field_valid = r_field_valid;
    assign msg_type    = r_msg_type;
    assign order_id    = r_order_id;
    assign price       = r_price;
    assign volume      = r_volume;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_msg_parser.sv
// tb_msg_parser: directed self-checking bench for msg_parser (TIMEOUT_CYCLES=16).
// Builds with or without MSG_PARSER_CHECKSUM_EN.
module tb_msg_parser;

`ifdef MSG_PARSER_CHECKSUM_EN
    localparam int FB = 18;
`else
    localparam int FB = 17;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        field_valid;
    logic        out_ready;
    logic [7:0]  msg_type;
    logic [63:0] order_id;
    logic [31:0] price;
    logic [31:0] volume;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_bad    = 0;

    logic [7:0]   csum_corrupt = 8'h00;
    logic         mon_en = 1'b0;
    int           rec_cnt = 0;
    int           ready_low = 0;
    logic [135:0] rec_rec [4];

    msg_parser #(
        .TIMEOUT_CYCLES(16),
        .ERR_W         (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .field_valid(field_valid),
        .out_ready  (out_ready),
        .msg_type   (msg_type),
        .order_id   (order_id),
        .price      (price),
        .volume     (volume),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One line per delivered record; also the back-to-back monitor.
    always @(negedge clk) begin
        if (field_valid && out_ready && rst_n) begin
            $display("record type=%h oid=%h price=%h vol=%h err=%0d",
                     msg_type, order_id, price, volume, err_count);
        end
        if (mon_en) begin
            if (field_valid && out_ready) begin
                if (rec_cnt < 4) rec_rec[rec_cnt] = {msg_type, order_id, price, volume};
                rec_cnt++;
            end
            if (!in_ready) ready_low++;
        end
    end

    // Drive one byte from a negedge; returns at the negedge after its transfer.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_bad++;
            $display("FAIL send_byte: in_ready stuck low got 0 want 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Send the first nbytes of a frame; a full frame gets its checksum byte too.
    task automatic send_frame(input logic [7:0] t, input logic [63:0] oid,
                              input logic [31:0] pr, input logic [31:0] vol,
                              input int nbytes);
        logic [135:0] bits;
        logic [7:0]   x;
        bits = {t, oid, pr, vol};
        x    = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            x ^= bits[135-8*i -: 8];
            send_byte(bits[135-8*i -: 8]);
        end
`ifdef MSG_PARSER_CHECKSUM_EN
        if (nbytes == 17) send_byte(x ^ csum_corrupt);
`else
        if (x == 8'hxx) $display("unreachable");
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (field_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", field_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++;
        if ({msg_type, order_id, price, volume} !== 136'h0) begin
            n_bad++; $display("FAIL reset_fields: got %h want 0", {msg_type, order_id, price, volume});
        end
        n_checks++;
        if (err_count !== 16'd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", err_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_trade();
        logic [135:0] bits;
        logic [7:0]   x;
        bits = {8'h54, 64'h1, 32'h0000_2710, 32'h0000_0064};
        x = 8'h00;
        for (int i = 0; i < 16; i++) begin
            x ^= bits[135-8*i -: 8];
            send_byte(bits[135-8*i -: 8]);
        end
        n_checks++;
        if (field_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", field_valid); end
        x ^= bits[7:0];
        send_byte(bits[7:0]);
`ifdef MSG_PARSER_CHECKSUM_EN
        n_checks++;
        if (field_valid !== 1'b0) begin n_bad++; $display("FAIL single_pre_chk: got %b want 0", field_valid); end
        send_byte(x);
`endif
        n_checks++;
        if (field_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", field_valid); end
        n_checks++;
        if ({msg_type, order_id, price, volume} !== bits) begin
            n_bad++; $display("FAIL single_fields: got %h want %h", {msg_type, order_id, price, volume}, bits);
        end
        n_checks++;
        if (err_count !== 16'd0) begin n_bad++; $display("FAIL single_err: got %0d want 0", err_count); end
        @(negedge clk);
        n_checks++;
        if (field_valid !== 1'b0) begin n_bad++; $display("FAIL single_pulse: got %b want 0", field_valid); end
    endtask

    task automatic test_back_to_back();
        time t0;
        int  cycles;
        rec_cnt = 0; ready_low = 0; mon_en = 1'b1;
        t0 = $time;
        send_frame(8'h54, 64'hA1, 32'h100, 32'h10, 17);
        send_frame(8'h41, 64'hB2, 32'h200, 32'h20, 17);
        send_frame(8'h54, 64'hC3, 32'h300, 32'h30, 17);
        cycles = int'(($time - t0) / 10);
        @(negedge clk);
        mon_en = 1'b0;
        n_checks++;
        if (cycles != 3 * FB) begin n_bad++; $display("FAIL b2b_cycles: got %0d want %0d", cycles, 3 * FB); end
        n_checks++;
        if (rec_cnt != 3) begin n_bad++; $display("FAIL b2b_records: got %0d want 3", rec_cnt); end
        n_checks++;
        if (ready_low != 0) begin n_bad++; $display("FAIL b2b_in_ready: got %0d low cycles want 0", ready_low); end
        n_checks++;
        if (rec_rec[0] !== {8'h54, 64'hA1, 32'h100, 32'h10}) begin n_bad++; $display("FAIL b2b_rec0: got %h want %h", rec_rec[0], {8'h54, 64'hA1, 32'h100, 32'h10}); end
        n_checks++;
        if (rec_rec[1] !== {8'h41, 64'hB2, 32'h200, 32'h20}) begin n_bad++; $display("FAIL b2b_rec1: got %h want %h", rec_rec[1], {8'h41, 64'hB2, 32'h200, 32'h20}); end
        n_checks++;
        if (rec_rec[2] !== {8'h54, 64'hC3, 32'h300, 32'h30}) begin n_bad++; $display("FAIL b2b_rec2: got %h want %h", rec_rec[2], {8'h54, 64'hC3, 32'h300, 32'h30}); end
    endtask

    task automatic test_leading_garbage();
        send_byte(8'h00);
        n_checks++;
        if (err_count !== 16'd1) begin n_bad++; $display("FAIL garbage_err1: got %0d want 1", err_count); end
        send_byte(8'hFF);
        n_checks++;
        if (err_count !== 16'd2) begin n_bad++; $display("FAIL garbage_err2: got %0d want 2", err_count); end
        send_frame(8'h41, 64'h0102_0304_0506_0708, 32'hDEAD_BEEF, 32'h5, 17);
        n_checks++;
        if ({field_valid, msg_type, order_id, price, volume} !== {1'b1, 8'h41, 64'h0102_0304_0506_0708, 32'hDEAD_BEEF, 32'h5}) begin
            n_bad++; $display("FAIL garbage_rec: got %h want %h", {field_valid, msg_type, order_id, price, volume},
                              {1'b1, 8'h41, 64'h0102_0304_0506_0708, 32'hDEAD_BEEF, 32'h5});
        end
        n_checks++;
        if (err_count !== 16'd2) begin n_bad++; $display("FAIL garbage_err_after: got %0d want 2", err_count); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        send_frame(8'h54, 64'h7777_0000_0000_0000, 32'h1, 32'h1, 6);
        repeat (14) @(negedge clk);
        n_checks++;
        if (err_count !== 16'd2) begin n_bad++; $display("FAIL timeout_early: got %0d want 2", err_count); end
        @(negedge clk);
        n_checks++;
        if (err_count !== 16'd3) begin n_bad++; $display("FAIL timeout_fire: got %0d want 3", err_count); end
        send_frame(8'h54, 64'h99, 32'h1234, 32'h5678, 17);
        n_checks++;
        if ({field_valid, msg_type, order_id, price, volume} !== {1'b1, 8'h54, 64'h99, 32'h1234, 32'h5678}) begin
            n_bad++; $display("FAIL timeout_next: got %h want %h", {field_valid, msg_type, order_id, price, volume},
                              {1'b1, 8'h54, 64'h99, 32'h1234, 32'h5678});
        end
        @(negedge clk);
    endtask

    // A byte arriving in the very cycle the timeout would fire keeps the message.
    task automatic test_timeout_boundary();
        logic [135:0] bits;
        logic [7:0]   x;
        bits = {8'h41, 64'h55, 32'h66, 32'h77};
        x = 8'h00;
        for (int i = 0; i < FB; i++) begin
            if (i < 17) begin
                x ^= bits[135-8*i -: 8];
                send_byte(bits[135-8*i -: 8]);
            end else begin
                send_byte(x);
            end
            if (i < FB - 1) repeat (14) @(negedge clk);
        end
        n_checks++;
        if ({field_valid, msg_type, order_id, price, volume} !== {1'b1, bits}) begin
            n_bad++; $display("FAIL boundary_rec: got %h want %h", {field_valid, msg_type, order_id, price, volume}, {1'b1, bits});
        end
        n_checks++;
        if (err_count !== 16'd3) begin n_bad++; $display("FAIL boundary_err: got %0d want 3", err_count); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [135:0] held;
        out_ready = 1'b0;
        send_frame(8'h54, 64'hABCD, 32'h42, 32'h24, 17);
        held = {msg_type, order_id, price, volume};
        n_checks++;
        if (held !== {8'h54, 64'hABCD, 32'h42, 32'h24}) begin
            n_bad++; $display("FAIL bp_rec: got %h want %h", held, {8'h54, 64'hABCD, 32'h42, 32'h24});
        end
        // An offered garbage byte must not be taken while the record is pending.
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({field_valid, in_ready, msg_type, order_id, price, volume} !== {2'b10, held}) begin
                n_bad++; $display("FAIL bp_hold%0d: got %h want %h", i,
                                  {field_valid, in_ready, msg_type, order_id, price, volume}, {2'b10, held});
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (err_count !== 16'd3) begin n_bad++; $display("FAIL bp_err: got %0d want 3", err_count); end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (field_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b want 0", field_valid); end
        send_frame(8'h41, 64'h1111, 32'h2222, 32'h3333, 17);
        n_checks++;
        if ({field_valid, msg_type, order_id, price, volume} !== {1'b1, 8'h41, 64'h1111, 32'h2222, 32'h3333}) begin
            n_bad++; $display("FAIL bp_next: got %h want %h", {field_valid, msg_type, order_id, price, volume},
                              {1'b1, 8'h41, 64'h1111, 32'h2222, 32'h3333});
        end
        @(negedge clk);
    endtask

`ifdef MSG_PARSER_CHECKSUM_EN
    task automatic test_checksum();
        csum_corrupt = 8'h00;
        send_frame(8'h54, 64'h4242, 32'h10, 32'h20, 17);
        n_checks++;
        if ({field_valid, msg_type, order_id, price, volume} !== {1'b1, 8'h54, 64'h4242, 32'h10, 32'h20}) begin
            n_bad++; $display("FAIL csum_good: got %h want %h", {field_valid, msg_type, order_id, price, volume},
                              {1'b1, 8'h54, 64'h4242, 32'h10, 32'h20});
        end
        @(negedge clk);
        csum_corrupt = 8'h01;
        send_frame(8'h41, 64'h4343, 32'h11, 32'h21, 17);
        csum_corrupt = 8'h00;
        n_checks++;
        if (field_valid !== 1'b0) begin n_bad++; $display("FAIL csum_bad_valid: got %b want 0", field_valid); end
        n_checks++;
        if (err_count !== 16'd4) begin n_bad++; $display("FAIL csum_bad_err: got %0d want 4", err_count); end
    endtask
`endif

    task automatic test_reset_mid_message();
        send_frame(8'h54, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h0, 6);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({field_valid, in_ready, err_count} !== {2'b01, 16'd0}) begin
            n_bad++; $display("FAIL midrst_async: got %h want %h", {field_valid, in_ready, err_count}, {2'b01, 16'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (err_count !== 16'd0) begin n_bad++; $display("FAIL midrst_err: got %0d want 0", err_count); end
        send_frame(8'h41, 64'hFEED, 32'hCAFE, 32'hBEEF, 17);
        n_checks++;
        if ({field_valid, msg_type, order_id, price, volume} !== {1'b1, 8'h41, 64'hFEED, 32'hCAFE, 32'hBEEF}) begin
            n_bad++; $display("FAIL midrst_next: got %h want %h", {field_valid, msg_type, order_id, price, volume},
                              {1'b1, 8'h41, 64'hFEED, 32'hCAFE, 32'hBEEF});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_trade();
        test_back_to_back();
        test_leading_garbage();
        test_timeout();
        test_timeout_boundary();
        test_backpressure();
`ifdef MSG_PARSER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_message();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/msg_parser.md
# msg_parser

Byte-stream message parser feeding the trading decision stage. It accepts bytes over a valid/ready handshake, frames fixed-length big-endian market messages, and presents one parsed record (type, order ID, price, volume) per message on a registered valid/ready output. Unknown type bytes and stalled messages are discarded and counted, so the stream resynchronises without a reset.

## Interface
- TIMEOUT_CYCLES, default 1024: idle cycles allowed between bytes inside a message before it is abandoned; 0 disables the timeout.
- ERR_W, default 16: width of the saturating error counter.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  parser can accept a byte; a byte transfers when in_valid && in_ready.
- field_valid  out  1  parsed record valid.
- out_ready  in  1  downstream accepts record; record transfers when field_valid && out_ready.
- msg_type  out  8  message type byte.
- order_id  out  64  order ID, big-endian on the wire.
- price  out  32  price, big-endian.
- volume  out  32  volume, big-endian.
- err_count  out  ERR_W  discarded-message/byte count, saturating.

## Operation
- Frame: type byte, then 8 order_id bytes, 4 price bytes, 4 volume bytes; 17 bytes total, MSB first per field.
- Accepted types: 8'h54 (trade), 8'h41 (add). Any other byte received in IDLE is dropped, err_count increments, and the state stays IDLE.
- States:
  - IDLE: waits for a valid type byte, then goes to BODY with byte index 1.
  - BODY: shifts each accepted byte into the assembly register, e.g. order_id_sh <= {order_id_sh[55:0], in_data}. After byte 16, goes to IDLE, or to CHK if checksum is enabled.
  - CHK: see Configuration.
- On frame completion, the assembly registers are copied to the output registers and field_valid is set.
- in_ready = !field_valid || out_ready. An unconsumed record blocks all further input, including bytes of the next message.
- field_valid clears on out_ready unless a new record completes in the same cycle; in that case it stays high with the new contents.
- Timeout: a counter clears on every accepted byte and increments each cycle in BODY or CHK. When it reaches TIMEOUT_CYCLES - 1:
  - the state returns to IDLE,
  - the partial message is discarded,
  - err_count increments.
- The timeout counter does not run while input is blocked by out_ready, because in_ready is low.
- err_count saturates at all ones; it never wraps.

## Timing
- Reset values:
  - outputs: field_valid 0, msg_type 0, order_id 0, price 0, volume 0, err_count 0, in_ready 1;
  - internal: state IDLE, byte index 0, timeout counter 0.
- Latency: field_valid rises exactly 1 cycle after the final byte's handshake.
- Throughput: with out_ready tied high, back-to-back 17-byte messages run at 1 byte/cycle with no bubble.
- Output fields are stable while field_valid && !out_ready.
- Reset asserted mid-message abandons the partial message; the error counter is not incremented for it.
- Simultaneous timeout expiry and byte acceptance: the byte wins and the timeout counter clears.

## Configuration
- MSG_PARSER_CHECKSUM_EN defined:
  - an 18th byte follows volume;
  - the CHK state compares it with the XOR of all 17 preceding bytes;
  - on match the record is emitted;
  - on mismatch the record is dropped, err_count increments, and the state returns to IDLE.
- Undefined: 17-byte frames, no CHK state, no checksum logic.

## Structure
- parser_pkg holds:
  - MSG_TRADE = 8'h54, MSG_ADD = 8'h41;
  - MSG_LEN = 17;
  - the state enum typedef (IDLE, BODY, CHK).
- Sub-module: msg_timeout_counter, parameterised by TIMEOUT_CYCLES, with clear/enable inputs and an expired output.

## Test plan
- Single trade frame 54 | 00..00 01 | 00 00 27 10 | 00 00 00 64, out_ready=1 -> one field_valid pulse 1 cycle after the last byte; order_id=1, price=10000, volume=100; err_count=0.
- Three back-to-back frames (54, 41, 54), in_valid high for 51 cycles -> three records; in_ready never low.
- Leading bytes 00 FF, then a valid frame -> err_count=2, one correct record.
- 5 body bytes then silence, TIMEOUT_CYCLES=16 -> return to IDLE after 15 idle cycles; err_count=1; the next frame parses correctly.
- out_ready=0 for 10 cycles after a record -> in_ready=0, outputs held stable; record consumed on release; next frame parses.
- With MSG_PARSER_CHECKSUM_EN, a correct XOR byte -> record emitted; a corrupted XOR byte -> no record, err_count=1.
